// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem arbiter: size codes, issue entry layout and
// the alignment check used on every granted access.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 2;

  localparam logic [BE_W-1:0] BE_BYTE = 2'b00;
  localparam logic [BE_W-1:0] BE_HALF = 2'b01;
  localparam logic [BE_W-1:0] BE_WORD = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [BE_W-1:0]   be;
    logic              err;
  } issue_t;

  // Size code 11 is illegal; byte accesses are legal at any offset.
  function automatic logic misaligned(input logic [BE_W-1:0] be, input logic [1:0] a_lo);
    logic bad;
    case (be)
      BE_BYTE: bad = 1'b0;
      BE_HALF: bad = a_lo[0];
      BE_WORD: bad = |a_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter with a bounded lock: a locked owner keeps the
// grant for at most LOCK_MAX consecutive contested cycles.
module rr_arb2 #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic          rr_ptr;
  logic          owner;
  logic          locked;
  logic [CW-1:0] lock_cnt;
  logic          saturated;
  logic          win;

  assign saturated = (lock_cnt >= CW'(LOCK_MAX));

  always_comb begin
    gnt = 2'b00;
    win = req[1];
    if (req == 2'b11) begin
      if (locked) win = saturated ? ~owner : owner;
      else        win = rr_ptr;
    end
    if (!rst && (req != 2'b00)) gnt = win ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      locked   <= 1'b0;
      lock_cnt <= '0;
    end else if (|gnt) begin
      rr_ptr <= ~win;
      if (lock[win]) begin
        owner  <= win;
        locked <= 1'b1;
        if (locked && (owner == win)) begin
          if (!saturated) lock_cnt <= lock_cnt + 1'b1;
        end else begin
          lock_cnt <= CW'(1);
        end
      end else begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end
    end else if (locked && !req[owner]) begin
      locked   <= 1'b0;
      lock_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported dmem between two masters: grant, legality check,
// one-deep issue register driving dmem, and a registered response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_i,
  input  logic [1:0]  lock_i,
  input  logic [1:0]  we_i,
  input  logic [63:0] a_i,
  input  logic [63:0] wd_i,
  input  logic [3:0]  be_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_be,
  input  logic [31:0] mem_rd
);

  logic [1:0]  gnt;
  logic        sel;
  issue_t      iss_d, iss_q;
  logic [1:0]  rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  rr_arb2 #(
    .LOCK_MAX(LOCK_MAX)
  ) u_arb (
    .clk (clk),
    .rst (reset),
    .req (req_i),
    .lock(lock_i),
    .gnt (gnt)
  );

  assign gnt_o = gnt;
  assign sel   = gnt[1];

  // Idle cycles only clear valid; the payload holds so dmem inputs stay quiet.
  always_comb begin
    iss_d       = iss_q;
    iss_d.valid = |gnt;
    if (|gnt) begin
      iss_d.port = sel;
      iss_d.we   = we_i[sel];
      iss_d.a    = sel ? a_i[63:32]  : a_i[31:0];
      iss_d.wd   = sel ? wd_i[63:32] : wd_i[31:0];
      iss_d.be   = sel ? be_i[3:2]   : be_i[1:0];
      iss_d.err  = misaligned(iss_d.be, iss_d.a[1:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_q <= '{valid: 1'b0, port: 1'b0, we: 1'b0, a: '0, wd: '0, be: BE_WORD, err: 1'b0};
    end else begin
      iss_q <= iss_d;
    end
  end

  assign mem_we = iss_q.valid & iss_q.we & ~iss_q.err;
  assign mem_a  = iss_q.a;
  assign mem_wd = iss_q.wd;
  assign mem_be = iss_q.be;

  // Stores also respond; mem_rd is sampled before the write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= iss_q.valid ? (iss_q.port ? 2'b10 : 2'b01) : 2'b00;
      err_q    <= iss_q.valid & iss_q.err;
      rdata_q  <= iss_q.err ? '0 : mem_rd;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported data memory `dmem`. It shares `dmem` between the core load/store path (port 0) and an auxiliary master (port 1, program loader/debug). It uses round-robin arbitration with an optional bounded lock. Every access is registered into a one-deep issue stage, so `dmem` sees clean single-cycle write pulses. Misaligned or illegal accesses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- `LOCK_MAX`, default 8: maximum consecutive locked grants to one port while the other port is requesting.

Ports:
- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `reset`: in, 1. Asynchronous, active-high.
- `req_i`: in, 2. Per-port access request. Held until the port is granted.
- `lock_i`: in, 2. Per-port lock hint: keep ownership for the next access.
- `we_i`: in, 2. Per-port write enable (0 = load).
- `a_i`: in, 64. Per-port byte address, port p at `[32p+31:32p]`.
- `wd_i`: in, 64. Per-port write data, same packing as `a_i`.
- `be_i`: in, 4. Per-port size code at `[2p+1:2p]`: 00 byte, 01 half, 10 word, 11 illegal.
- `gnt_o`: out, 2. One-hot or zero. Combinational in the request cycle.
- `rvalid_o`: out, 2. One-cycle response pulse to the port that owned the access.
- `rdata_o`: out, 32. Raw memory word at the accessed word address; 0 on error.
- `err_o`: out, 1. Qualifies `rvalid_o`. 1 = access rejected.
- `mem_we`: out, 1. Drives dmem `we`.
- `mem_a`: out, 32. Drives dmem `a`.
- `mem_wd`: out, 32. Drives dmem `wd`.
- `mem_be`: out, 2. Drives dmem `be`.
- `mem_rd`: in, 32. dmem `rd`, combinational read data.

## Operation
- **Arbitration (cycle N):**
  - If exactly one port requests, that port wins.
  - If both request:
    - A locked owner with `lock_cnt < LOCK_MAX` wins.
    - Otherwise the port selected by round-robin pointer `rr_ptr` wins.
  - `gnt_o[p]=1` for the winner only. `req_i` with no grant means the port retries; there is no loss.
- **Pointer update** on every grant: `rr_ptr` <= the other port.
- **Lock tracking:**
  - Grant with `lock_i[p]=1`: `owner<=p`, `locked<=1`.
    - `lock_cnt` increments when p is already the owner.
    - `lock_cnt` is set to 1 when ownership changes.
  - Grant with `lock_i[p]=0`: `locked<=0`, `lock_cnt<=0`.
  - A cycle where the locked owner does not request: `locked<=0`, `lock_cnt<=0`.
  - `lock_cnt` saturates at `LOCK_MAX`. At saturation, a requesting non-owner wins and the lock clears.
- **Legality check** on the winning request:
  - Illegal if `be=11`.
  - Illegal if half with `a[0]=1`.
  - Illegal if word with `a[1:0]!=00`.
  - Byte is legal at any offset.
- **Issue stage:**
  - A grant loads `{valid, port, we, a, wd, be, err}` into the issue register.
  - No grant loads `valid=0`.
- **Memory drive (cycle N+1):**
  - `mem_a`, `mem_wd`, `mem_be` come from the issue register.
  - `mem_we = valid & we & ~err`.
  - Invalid or erroneous entries drive `mem_we=0`.
- **Response register** (loaded at the end of N+1):
  - `rvalid_o[port] <= valid`.
  - `err_o <= err`.
  - `rdata_o <= err ? 0 : mem_rd`.
- Stores also return `rvalid`; their `rdata_o` is the pre-write word.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to memory access: 1 cycle. The store commits on the edge ending N+1.
- Grant to `rvalid`: 2 cycles.
- Throughput: one grant per cycle, with back-to-back accesses to either port fully pipelined.
- A load at N+1 following a store at N sees the new data, because the write commits before the read cycle.
- Simultaneous requests with no lock: strictly alternate ports.
- **Reset values** (asynchronous, while `reset=1`):
  - `gnt_o=0`, `rvalid_o=0`, `err_o=0`, `rdata_o=0`.
  - `mem_we=0`, `mem_a=0`, `mem_wd=0`, `mem_be=2'b10`.
  - `rr_ptr=0`, `locked=0`, `lock_cnt=0`, issue valid=0.
- **Reset mid-operation:**
  - An in-flight access is dropped with no write and no `rvalid`.
  - A store already committed on an edge before reset stays committed.
- `gnt_o` is forced 0 while `reset=1`.

## Structure
- Shared package `dmem_pkg` holds:
  - Constants `BE_BYTE=2'b00`, `BE_HALF=2'b01`, `BE_WORD=2'b10`.
  - Function `misaligned(be, a_lo)`.
  - The issue-entry field widths.
- Sub-module `rr_arb2` contains the round-robin pointer, lock owner/flag and `lock_cnt`. It takes `req`, `lock` and outputs a one-hot `gnt`.
- The top level contains only the legality check, the issue register and the response register.

## Test plan
- After reset, port 0 loads word at 0x10 holding 0xDEADBEEF:
  - `gnt_o=01` in N, `mem_a=0x10` in N+1.
  - `rvalid_o=01`, `rdata_o=0xDEADBEEF`, `err_o=0` in N+2.
- Both ports request every cycle with `lock_i=0`: grants alternate 01,10,01,10. Each `rvalid` arrives two cycles after its grant.
- Port 1 requests continuously with `lock_i[1]=1`, port 0 requests continuously, `LOCK_MAX=4`:
  - Grant sequence: 10 ×4, then 01, then port 1 resumes.
  - No more than 4 consecutive grants go to port 1.
- Port 0 stores half at 0x21, then word at 0x22:
  - Both respond `err_o=1`, `rdata_o=0`.
  - `mem_we` never 1.
  - Memory contents unchanged.
- Port 0 stores word 0x12345678 at 0x40 in cycle N, port 1 loads 0x40 in N+1: port 1 `rdata_o=0x12345678`.
- Assert `reset` in the cycle after granting a store to 0x40:
  - No `mem_we` pulse, no `rvalid`.
  - Location 0x40 keeps its old value.
  - All outputs hold their reset values.
